aes_req_scheduler: RTL and testbench
====================================

# aes_req_scheduler

Round-robin scheduler that shares a single `aes_core` encryption engine among `NUM_REQ` requesters. It accepts one plaintext/key job at a time, issues it to the core with a one-cycle start pulse, and waits for the core's done level, guarded by a watchdog. It then returns the ciphertext to the owning requester over a valid/ready response channel. It sits between the requester-side bus logic and the core.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 16: maximum WAIT cycles without `core_done` before an error response; ≥ 4.
- `IDW`, default `$clog2(NUM_REQ)`: grant index width.

Ports:
- `clk`  in  1  clock; reset `rst` is asynchronous, active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester job request.
- `req_ready`  out  NUM_REQ  one-hot accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_plaintext`  in  NUM_REQ*128  requester i occupies bits `[i*128 +: 128]`.
- `req_key`  in  NUM_REQ*128  same packing as `req_plaintext`.
- `rsp_valid`  out  NUM_REQ  one-hot; response pending for that requester.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `rsp_data`  out  128  ciphertext, or 0 on error.
- `rsp_err`  out  1  response is a timeout error.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_plaintext`, `core_key`  out  128 each  job operands, held stable from ISSUE through WAIT.
- `core_done`  in  1  core completion level; stays high until the next accepted start.
- `core_ciphertext`  in  128  core result.
- `busy`  out  1  high whenever the state is not IDLE.
- `grant_id`  out  IDW  index of the requester currently owning the core.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- **IDLE**
  - Selection is combinational. The scheduler searches `req_valid` round-robin, starting at `last_grant+1` and wrapping at NUM_REQ.
  - `req_ready` is asserted only on the selected index, and only in IDLE.
  - On transfer: latch plaintext, key and `grant_id`, then go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - Assert `core_start` for exactly one cycle and clear the watchdog counter.
  - Go to WAIT.
- **WAIT**
  - Increment the watchdog every cycle.
  - If `core_done`=1: latch `rsp_data`=`core_ciphertext` and `rsp_err`=0, then go to RESP.
  - Else if the watchdog reaches TIMEOUT: set `rsp_data`=0 and `rsp_err`=1, then go to RESP.
  - If both conditions hold in the same cycle, done wins.
- **RESP**
  - Hold `rsp_valid[grant_id]` high, with `rsp_data` and `rsp_err` stable, until `rsp_ready[grant_id]`=1.
  - On that handshake: `last_grant`=`grant_id`, drop `rsp_valid`, go to GAP.
  - There is no timeout on `rsp_ready`. A stalled requester blocks all others.
- **GAP**
  - One idle cycle so the core can return to its idle state, then go to IDLE.
- A requester may re-request during its own RESP. That request is considered only in IDLE, after the round-robin pointer has advanced past it.
- `rsp_valid` bits other than `grant_id` are always 0, and `rsp_valid` is never asserted outside RESP.

## Timing
- Reset values: state=IDLE; `last_grant`=NUM_REQ-1, so requester 0 wins first.
- All outputs are 0 in reset: `req_ready` (forced 0 while `rst` is high), `rsp_valid`, `rsp_data`, `rsp_err`, `core_start`, `core_plaintext`, `core_key`, `busy`, `grant_id`.
- Reset mid-operation aborts the job immediately. No response is produced. A pending `rsp_valid` drops asynchronously.
- The acceptance cycle is cycle 0. Then:
  - cycle 1: ISSUE, `core_start` high.
  - cycles 2–3: WAIT; the core raises `core_done` in cycle 3.
  - cycle 4: `rsp_valid` high.
- With `rsp_ready` held high: handshake at cycle 4, GAP at 5, IDLE at 6. The next acceptance happens no earlier than cycle 6, so each job occupies 6 cycles.
- A stale `core_done`=1 during ISSUE is ignored. `core_done` is sampled only in WAIT.
- Timeout: `rsp_valid` rises on cycle 2+TIMEOUT when the core never asserts done.

## Test plan
- **Single job.** Requester 2 sends plaintext 0x00112233445566778899AABBCCDDEEFF with key 0x000102030405060708090A0B0C0D0E0F.
  - Required: `req_ready[2]` in cycle 0, `core_start` in cycle 1, `rsp_valid[2]` in cycle 4.
  - `rsp_data` equals `core_ciphertext`, `rsp_err`=0.
- **Round robin.** All four requesters hold `req_valid` continuously with `rsp_ready` high.
  - Grants go 0, 1, 2, 3, 0, with acceptances 6 cycles apart.
  - `rsp_valid` stays one-hot and matches `grant_id`.
- **Response backpressure.** Hold `rsp_ready[1]` low for 10 cycles.
  - `rsp_valid[1]`, `rsp_data` and `busy` stay stable.
  - `req_ready` stays 0 for all requesters.
  - Release: GAP follows, then the next grant.
- **Watchdog.** Replace the core with a stub whose `core_done` stays 0, TIMEOUT=16.
  - `rsp_valid` at cycle 18, `rsp_err`=1, `rsp_data`=0.
  - The next request proceeds normally.
- **Asynchronous reset.** Assert `rst` during WAIT.
  - All outputs go to 0 immediately.
  - After release, requester 0 wins a simultaneous 0/3 request.
- **Stale done.** The stub holds `core_done`=1 through ISSUE and drops it one cycle later.
  - No early response. The response is issued only on `core_done` re-asserting in WAIT.

Source files
------------

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler sharing one AES core among NUM_REQ requesters.
// One job in flight at a time: accept, issue a start pulse, wait for done
// (watchdog-guarded), return the ciphertext on a valid/ready response channel.
module aes_req_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_plaintext,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [127:0]           rsp_data,
    output logic                   rsp_err,
    output logic                   core_start,
    output logic [127:0]           core_plaintext,
    output logic [127:0]           core_key,
    input  logic                   core_done,
    input  logic [127:0]           core_ciphertext,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id
);

    // Watchdog must be able to count up to TIMEOUT-1.
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StGap
    } state_e;

    state_e             state_q;
    logic [IDW-1:0]     last_grant_q;
    logic [WDW-1:0]     wd_q;

    logic               sel_found;
    logic [IDW-1:0]     sel_idx;
    logic [IDW-1:0]     rr_idx;
    logic [127:0]       sel_pt;
    logic [127:0]       sel_key;
    logic [NUM_REQ-1:0] grant_onehot;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_idx = IDW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!sel_found && req_valid[rr_idx]) begin
                sel_found = 1'b1;
                sel_idx   = rr_idx;
            end
        end
    end

    // Operand mux for the selected lane.
    always_comb begin
        sel_pt  = '0;
        sel_key = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (sel_idx == IDW'(i)) begin
                sel_pt  = req_plaintext[i*128 +: 128];
                sel_key = req_key[i*128 +: 128];
            end
        end
    end

    assign grant_onehot = NUM_REQ'(1) << grant_id;

    // Ready is only offered in IDLE, and never while reset is asserted.
    assign req_ready = (state_q == StIdle && sel_found && !rst) ? (NUM_REQ'(1) << sel_idx) : '0;

    assign busy = (state_q != StIdle);

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            last_grant_q   <= IDW'(NUM_REQ - 1);
            wd_q           <= '0;
            grant_id       <= '0;
            core_start     <= 1'b0;
            core_plaintext <= '0;
            core_key       <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
        end else begin
            core_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        core_plaintext <= sel_pt;
                        core_key       <= sel_key;
                        grant_id       <= sel_idx;
                        core_start     <= 1'b1;
                        state_q        <= StIssue;
                    end
                end
                StIssue: begin
                    // core_done is deliberately not looked at here: it may
                    // still be high from the previous job.
                    wd_q    <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    wd_q <= wd_q + WDW'(1);
                    if (core_done) begin
                        rsp_data  <= core_ciphertext;
                        rsp_err   <= 1'b0;
                        rsp_valid <= grant_onehot;
                        state_q   <= StResp;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= grant_onehot;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    // No timeout here: a stalled requester holds the core.
                    if (rsp_ready[grant_id]) begin
                        last_grant_q <= grant_id;
                        rsp_valid    <= '0;
                        state_q      <= StGap;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Self-checking bench for aes_req_scheduler with a behavioural core stub.
module tb_aes_req_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned IDW     = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_plaintext;
    logic [NUM_REQ*128-1:0] req_key;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ-1:0]     rsp_ready;
    logic [127:0]           rsp_data;
    logic                   rsp_err;
    logic                   core_start;
    logic [127:0]           core_plaintext;
    logic [127:0]           core_key;
    logic                   core_done;
    logic [127:0]           core_ciphertext;
    logic                   busy;
    logic [IDW-1:0]         grant_id;

    int compared   = 0;
    int mismatched = 0;
    int cycle_cnt  = 0;

    // 0: normal core, 1: core never finishes, 2: done driven by the bench
    int   mode        = 0;
    logic manual_done = 1'b0;

    typedef struct {
        int           id;
        logic [127:0] data;
        logic         err;
    } exp_t;
    exp_t sb_q[$];

    aes_req_scheduler #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT(TIMEOUT),
        .IDW    (IDW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_plaintext  (req_plaintext),
        .req_key        (req_key),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .core_start     (core_start),
        .core_plaintext (core_plaintext),
        .core_key       (core_key),
        .core_done      (core_done),
        .core_ciphertext(core_ciphertext),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Stand-in cipher: the scheduler only forwards it, so any mixing will do.
    function automatic logic [127:0] cipher(input logic [127:0] p, input logic [127:0] k);
        return p ^ {k[63:0], k[127:64]} ^ 128'h5A5A_5A5A_C3C3_C3C3_0F0F_0F0F_9696_9696;
    endfunction

    // Core stub: done two cycles after the start pulse, held until next start.
    logic         model_done = 1'b0;
    logic         model_pend = 1'b0;
    logic [127:0] model_ct   = '0;
    always @(posedge clk) begin
        if (core_start) begin
            model_done <= 1'b0;
            model_pend <= 1'b1;
            model_ct   <= cipher(core_plaintext, core_key);
        end else if (model_pend) begin
            model_pend <= 1'b0;
            model_done <= 1'b1;
        end
    end
    assign core_done       = (mode == 1) ? 1'b0 : (mode == 2) ? manual_done : model_done;
    assign core_ciphertext = model_ct;

    // Scoreboard: push on accepted request, pop/compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.id   = i;
                    e.err  = (mode == 1);
                    e.data = (mode == 1) ? 128'h0
                           : cipher(req_plaintext[i*128 +: 128], req_key[i*128 +: 128]);
                    sb_q.push_back(e);
                end
            end
            if (rsp_valid != '0) begin
                compared++;
                if (rsp_valid !== (4'b0001 << grant_id)) begin
                    mismatched++;
                    $display("FAIL rsp_onehot got rsp_valid=%b want one-hot of grant_id=%0d",
                             rsp_valid, grant_id);
                end
                if ((rsp_valid & rsp_ready) != '0) begin
                    compared++;
                    if (sb_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_unexpected got response rsp_valid=%b want none",
                                 rsp_valid);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        if (rsp_valid !== (4'b0001 << e.id) || rsp_data !== e.data ||
                            rsp_err !== e.err) begin
                            mismatched++;
                            $display("FAIL sb_rsp got id=%b data=%h err=%b want id=%0d data=%h err=%b",
                                     rsp_valid, rsp_data, rsp_err, e.id, e.data, e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [127:0] p, input logic [127:0] k);
        req_plaintext[i*128 +: 128] = p;
        req_key[i*128 +: 128]       = k;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 4'b1111;
        for (int i = 0; i < int'(NUM_REQ); i++)
            set_lane(i, {4{32'h1000_0000 + 32'(i)}}, {4{32'hCAFE_0000 + 32'(i)}});
        #12;
        compared++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_err !== 1'b0 || core_start !== 1'b0
            || busy !== 1'b0 || grant_id !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl got rdy=%b rv=%b err=%b st=%b busy=%b gid=%0d want all 0",
                     req_ready, rsp_valid, rsp_err, core_start, busy, grant_id);
        end
        compared++;
        if (rsp_data !== 128'h0 || core_plaintext !== 128'h0 || core_key !== 128'h0) begin
            mismatched++;
            $display("FAIL reset_data got rsp=%h pt=%h key=%h want 0",
                     rsp_data, core_plaintext, core_key);
        end
        req_valid = 4'b0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        logic [127:0] pt  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        logic [127:0] key = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
        int n;
        mode = 0;
        set_lane(2, pt, key);
        req_valid = 4'b0100; #1;
        compared++;
        if (req_ready !== 4'b0100) begin
            mismatched++; $display("FAIL single_ready got %b want 0100", req_ready);
        end
        cyc(); req_valid = 4'b0;
        compared++;
        if (core_start !== 1'b1 || grant_id !== 2'd2 || core_plaintext !== pt || core_key !== key)
        begin
            mismatched++;
            $display("FAIL single_issue got st=%b gid=%0d pt=%h key=%h want 1 2 %h %h",
                     core_start, grant_id, core_plaintext, core_key, pt, key);
        end
        cyc(); n = 2;
        compared++;
        if (core_start !== 1'b0) begin
            mismatched++; $display("FAIL single_start_pulse got %b want 0", core_start);
        end
        while (rsp_valid === 4'b0 && n < 20) begin cyc(); n++; end
        compared++;
        if (n !== 4 || rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_data !== cipher(pt, key))
        begin
            mismatched++;
            $display("FAIL single_rsp got cyc=%0d rv=%b err=%b data=%h want 4 0100 0 %h",
                     n, rsp_valid, rsp_err, rsp_data, cipher(pt, key));
        end
        cyc();
        compared++;
        if (rsp_valid !== 4'b0 || busy !== 1'b1) begin
            mismatched++; $display("FAIL single_gap got rv=%b busy=%b want 0 1", rsp_valid, busy);
        end
        cyc();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL single_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int prev = 0;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++)
            set_lane(i, {4{32'h1000_0000 + 32'(i)}}, {4{32'hCAFE_0000 + 32'(i)}});
        req_valid = 4'b1111; rsp_ready = 4'b1111; #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (req_ready === 4'b0 && n < 20) begin cyc(); #1; n++; end
            compared++;
            if (req_ready !== (4'b0001 << (g % 4))) begin
                mismatched++;
                $display("FAIL rr_grant%0d got %b want %b", g, req_ready, 4'b0001 << (g % 4));
            end
            if (g > 0) begin
                compared++;
                if (cycle_cnt - prev != 6) begin
                    mismatched++;
                    $display("FAIL rr_spacing%0d got %0d want 6", g, cycle_cnt - prev);
                end
            end
            prev = cycle_cnt;
            cyc(); #1;
        end
        req_valid = 4'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin cyc(); n++; end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL rr_drain got busy=%b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [127:0] held;
        req_valid = 4'b0010; rsp_ready = 4'b1101; #1;
        compared++;
        if (req_ready !== 4'b0010) begin
            mismatched++; $display("FAIL bp_ready got %b want 0010", req_ready);
        end
        cyc(); req_valid = 4'b1001;
        n = 0;
        while (rsp_valid === 4'b0 && n < 20) begin cyc(); n++; end
        held = rsp_data;
        for (int c = 0; c < 10; c++) begin
            cyc();
            compared++;
            if (rsp_valid !== 4'b0010 || rsp_data !== held || busy !== 1'b1 || req_ready !== 4'b0)
            begin
                mismatched++;
                $display("FAIL bp_stall%0d got rv=%b data=%h busy=%b rdy=%b want 0010 %h 1 0000",
                         c, rsp_valid, rsp_data, busy, req_ready, held);
            end
        end
        rsp_ready = 4'b1111;
        cyc();
        compared++;
        if (rsp_valid !== 4'b0 || busy !== 1'b1 || req_ready !== 4'b0) begin
            mismatched++;
            $display("FAIL bp_gap got rv=%b busy=%b rdy=%b want 0 1 0", rsp_valid, busy, req_ready);
        end
        cyc();
        compared++;
        if (req_ready !== 4'b1000) begin
            mismatched++; $display("FAIL bp_next got %b want 1000", req_ready);
        end
        req_valid = 4'b0;
        cyc();
    endtask

    task automatic test_watchdog();
        int n;
        mode = 1;
        req_valid = 4'b0001; #1;
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++; $display("FAIL wd_ready got %b want 0001", req_ready);
        end
        cyc(); req_valid = 4'b0; n = 1;
        while (rsp_valid === 4'b0 && n < 40) begin cyc(); n++; end
        compared++;
        if (n !== 18 || rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== 128'h0) begin
            mismatched++;
            $display("FAIL wd_timeout got cyc=%0d rv=%b err=%b data=%h want 18 0001 1 0",
                     n, rsp_valid, rsp_err, rsp_data);
        end
        cyc(); cyc();
        mode = 0;
        req_valid = 4'b0100; #1;
        compared++;
        if (req_ready !== 4'b0100) begin
            mismatched++; $display("FAIL wd_next_ready got %b want 0100", req_ready);
        end
        cyc(); req_valid = 4'b0; n = 1;
        while (rsp_valid === 4'b0 && n < 20) begin cyc(); n++; end
        compared++;
        if (n !== 4 || rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL wd_next_rsp got cyc=%0d err=%b want 4 0", n, rsp_err);
        end
        cyc(); cyc();
    endtask

    task automatic test_async_reset();
        int n;
        req_valid = 4'b0010; #1;
        compared++;
        if (req_ready !== 4'b0010) begin
            mismatched++; $display("FAIL ar_ready got %b want 0010", req_ready);
        end
        cyc(); req_valid = 4'b0;
        cyc();
        #1; rst = 1'b1; req_valid = 4'b1001;
        #1;
        compared++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_err !== 1'b0 || core_start !== 1'b0
            || busy !== 1'b0 || grant_id !== 2'd0 || rsp_data !== 128'h0
            || core_plaintext !== 128'h0 || core_key !== 128'h0) begin
            mismatched++;
            $display("FAIL ar_outputs got rdy=%b rv=%b err=%b st=%b busy=%b gid=%0d pt=%h want 0",
                     req_ready, rsp_valid, rsp_err, core_start, busy, grant_id, core_plaintext);
        end
        sb_q.delete();
        cyc();
        rst = 1'b0; #1;
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++; $display("FAIL ar_first_grant got %b want 0001", req_ready);
        end
        cyc(); req_valid = 4'b0; n = 1;
        while (rsp_valid === 4'b0 && n < 20) begin cyc(); n++; end
        compared++;
        if (n !== 4 || rsp_valid !== 4'b0001) begin
            mismatched++; $display("FAIL ar_rsp got cyc=%0d rv=%b want 4 0001", n, rsp_valid);
        end
        cyc(); cyc();
    endtask

    task automatic test_stale_done();
        logic [127:0] exp_ct;
        exp_ct = cipher(req_plaintext[3*128 +: 128], req_key[3*128 +: 128]);
        mode = 2; manual_done = 1'b1;
        req_valid = 4'b1000; #1;
        compared++;
        if (req_ready !== 4'b1000) begin
            mismatched++; $display("FAIL stale_ready got %b want 1000", req_ready);
        end
        cyc(); req_valid = 4'b0;
        compared++;
        if (core_start !== 1'b1) begin
            mismatched++; $display("FAIL stale_start got %b want 1", core_start);
        end
        cyc(); manual_done = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            compared++;
            if (rsp_valid !== 4'b0) begin
                mismatched++; $display("FAIL stale_early_c%0d got %b want 0000", c, rsp_valid);
            end
            if (c == 5) manual_done = 1'b1;
            cyc();
        end
        compared++;
        if (rsp_valid !== 4'b1000 || rsp_err !== 1'b0 || rsp_data !== exp_ct) begin
            mismatched++;
            $display("FAIL stale_rsp got rv=%b err=%b data=%h want 1000 0 %h",
                     rsp_valid, rsp_err, rsp_data, exp_ct);
        end
        cyc(); manual_done = 1'b0; mode = 0;
        cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_async_reset();
        test_stale_done();
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
